// File: rtl/alu_op_sequencer.sv
// Three-state sequencer that issues instructions to an external 4-bit ALU,
// owns a 4x4 register file and the carry flag, and writes ALU results back.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_cin,
  input  logic [3:0]  alu_result,
  output logic        res_valid,
  output logic [3:0]  res_data,
  output logic [1:0]  res_rd,
  output logic        carry_flag,
  output logic        err_pulse,
  input  logic [1:0]  dbg_sel,
  output logic [3:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] rf [4];

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] imm;
  logic       accept;
  logic       is_alu;
  logic       is_loadi;

  assign op       = instr[11:8];
  assign rd       = instr[7:6];
  assign ra       = instr[5:4];
  assign rb       = instr[3:2];
  assign imm      = instr[3:0];
  assign is_alu   = (op <= 4'hB);
  assign is_loadi = (op == 4'hF);

  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign alu_cin     = {3'b000, carry_flag};
  assign dbg_data    = rf[dbg_sel];

  // Flag logic works on the latched operands, which are held through EXEC
  logic [4:0] sum_ab;
  logic [4:0] sum_abc;
  logic [4:0] b_plus_c;
  logic       carry_next;

  assign sum_ab   = {1'b0, alu_a} + {1'b0, alu_b};
  assign sum_abc  = sum_ab + {4'b0000, carry_flag};
  assign b_plus_c = {1'b0, alu_b} + {4'b0000, carry_flag};

  always_comb begin
    carry_next = carry_flag;
    case (alu_op)
      4'h0:    carry_next = sum_ab[4];
      4'h1:    carry_next = sum_abc[4];
      4'h2:    carry_next = (alu_a < alu_b);
      4'h3:    carry_next = ({1'b0, alu_a} < b_plus_c);
      default: carry_next = carry_flag;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
      carry_flag <= 1'b0;
      res_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      res_data   <= 4'h0;
      res_rd     <= 2'd0;
      alu_a      <= 4'h0;
      alu_b      <= 4'h0;
      alu_op     <= 4'h0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_alu: begin
                alu_a  <= rf[ra];
                alu_b  <= rf[rb];
                alu_op <= op;
                res_rd <= rd;
                state  <= EXEC;
              end
              is_loadi: begin
                rf[rd]    <= imm;
                res_data  <= imm;
                res_rd    <= rd;
                res_valid <= 1'b1;
                state     <= WB;
              end
              default: err_pulse <= 1'b1;
            endcase
          end
        end
        EXEC: begin
          res_data   <= alu_result;
          rf[res_rd] <= alu_result;
          carry_flag <= carry_next;
          res_valid  <= 1'b1;
          state      <= WB;
        end
        WB: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a bench-side ALU
// and an instruction-level reference model of the register file and carry.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [11:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_cin;
  logic [3:0]  alu_result;
  logic        res_valid;
  logic [3:0]  res_data;
  logic [1:0]  res_rd;
  logic        carry_flag;
  logic        err_pulse;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  logic [3:0] rf_m [4];
  logic       c_m;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .carry_flag (carry_flag),
    .err_pulse  (err_pulse),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  function automatic logic [3:0] alu_fn(input logic [3:0] o, input int a,
                                        input int b, input int c);
    int r;
    case (o)
      4'h0: r = a + b;
      4'h1: r = a + b + c;
      4'h2: r = a - b;
      4'h3: r = a - b - c;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: r = a << 1;
      4'h9: r = a >> 1;
      4'hA: r = a;
      4'hB: r = b;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  // Bench-side combinational ALU
  always_comb alu_result = alu_fn(alu_op, int'(alu_a), int'(alu_b), int'(alu_cin));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: kind 0 = ALU, 1 = LOADI, 2 = illegal
  task automatic model_step(input logic [11:0] i, output logic [3:0] d,
                            output int kind);
    int a, b, c;
    logic [3:0] o;
    o = i[11:8];
    a = int'(rf_m[i[5:4]]);
    b = int'(rf_m[i[3:2]]);
    c = int'(c_m);
    d = 4'h0;
    if (o <= 4'hB) begin
      kind = 0;
      d = alu_fn(o, a, b, c);
      if (o == 4'h0) c_m = (a + b) > 15;
      if (o == 4'h1) c_m = (a + b + c) > 15;
      if (o == 4'h2) c_m = a < b;
      if (o == 4'h3) c_m = a < (b + c);
      rf_m[i[7:6]] = d;
    end else if (o == 4'hF) begin
      kind = 1;
      d = i[3:0];
      rf_m[i[7:6]] = d;
    end else begin
      kind = 2;
    end
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = r[1:0];
      #1;
      chk($sformatf("%s_rf%0d", tag, r), {4'h0, dbg_data}, {4'h0, rf_m[r]});
    end
  endtask

  // Drives one instruction at posedge+1 and follows it to completion
  task automatic issue(input logic [11:0] i);
    logic [3:0] a, b, d;
    logic       cin;
    int         kind;
    a   = rf_m[i[5:4]];
    b   = rf_m[i[3:2]];
    cin = c_m;
    instr = i;
    instr_valid = 1'b1;
    chk("ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    model_step(i, d, kind);
    if (kind == 0) begin
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, b);
      chk("alu_op", alu_op, i[11:8]);
      chk("alu_cin", alu_cin, {3'b000, cin});
      chk("exec_rv", res_valid, 0);
      chk("exec_ready", instr_ready, 0);
      @(posedge clk); #1;
      chk("wb_rv", res_valid, 1);
      chk("wb_data", res_data, d);
      chk("wb_rd", res_rd, i[7:6]);
      chk("wb_carry", carry_flag, c_m);
      chk("alu_a_hold", alu_a, a);
      dbg_sel = i[7:6];
      #1;
      chk("wb_dbg", dbg_data, d);
      @(posedge clk); #1;
      chk("post_rv", res_valid, 0);
      chk("post_ready", instr_ready, 1);
    end else if (kind == 1) begin
      chk("ld_rv", res_valid, 1);
      chk("ld_data", res_data, d);
      chk("ld_rd", res_rd, i[7:6]);
      chk("ld_ready", instr_ready, 0);
      chk("ld_carry", carry_flag, c_m);
      @(posedge clk); #1;
      chk("ld_post_rv", res_valid, 0);
      chk("ld_post_ready", instr_ready, 1);
      dbg_sel = i[7:6];
      #1;
      chk("ld_dbg", dbg_data, d);
    end else begin
      chk("ill_err", err_pulse, 1);
      chk("ill_rv", res_valid, 0);
      chk("ill_ready", instr_ready, 1);
      @(posedge clk); #1;
      chk("ill_err_clr", err_pulse, 0);
      chk("ill_rv2", res_valid, 0);
      chk("ill_carry", carry_flag, c_m);
      check_rf("ill");
    end
  endtask

  function automatic logic [11:0] enc(input logic [3:0] o, input logic [1:0] d,
                                      input logic [1:0] a, input logic [1:0] b);
    return {o, d, a, b, 2'b00};
  endfunction

  function automatic logic [11:0] ldi(input logic [1:0] d, input logic [3:0] v);
    return {4'hF, d, 2'b00, v};
  endfunction

  initial begin
    logic [11:0] s [3];
    logic [3:0]  exp_q [$];
    logic [3:0]  d;
    int          kind, last_acc, n_acc, busy;
    logic        acc_now, prev_rv;

    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 12'h000;
    dbg_sel = 2'd0;
    for (int r = 0; r < 4; r++) rf_m[r] = 4'h0;
    c_m = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_data", res_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_rel", instr_ready, 1);
    check_rf("rst");

    // Known-answer sequence
    issue(ldi(2'd1, 4'h9));
    issue(ldi(2'd2, 4'h8));
    issue(enc(4'h0, 2'd3, 2'd1, 2'd2));
    dbg_sel = 2'd3; #1;
    chk("kat_add_rf3", dbg_data, 4'h1);
    chk("kat_add_c", carry_flag, 1);
    chk("kat_add_data", res_data, 4'h1);
    issue(enc(4'h1, 2'd0, 2'd3, 2'd3));
    chk("kat_adc_data", res_data, 4'h3);
    chk("kat_adc_c", carry_flag, 0);
    issue(enc(4'h2, 2'd0, 2'd2, 2'd1));
    chk("kat_sub_data", res_data, 4'hF);
    chk("kat_sub_c", carry_flag, 1);
    issue(enc(4'h3, 2'd3, 2'd1, 2'd2));
    chk("kat_sbb_data", res_data, 4'h0);
    chk("kat_sbb_c", carry_flag, 0);

    // Illegal opcode
    issue(enc(4'hD, 2'd1, 2'd2, 2'd3));

    // Back-to-back stream with instr_valid held high
    s[0] = enc(4'h0, 2'd1, 2'd2, 2'd3);
    s[1] = enc(4'h6, 2'd2, 2'd1, 2'd0);
    s[2] = enc(4'h0, 2'd0, 2'd1, 2'd2);
    instr = s[0];
    instr_valid = 1'b1;
    last_acc = -1;
    n_acc = 0;
    busy = 0;
    prev_rv = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      acc_now = instr_valid & instr_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        model_step(s[n_acc], d, kind);
        exp_q.push_back(d);
        if (last_acc >= 0) chk("stream_gap", 8'(cyc - last_acc), 3);
        last_acc = cyc;
        n_acc++;
        busy = 2;
        if (n_acc < 3) instr = s[n_acc];
        else instr_valid = 1'b0;
      end
      chk("stream_ready", instr_ready, (busy == 0));
      if (busy > 0) busy--;
      chk("stream_rv_pair", prev_rv & res_valid, 0);
      if (res_valid) begin
        if (exp_q.size() == 0) chk("stream_extra_rv", res_valid, 0);
        else chk("stream_data", res_data, exp_q.pop_front());
      end
      prev_rv = res_valid;
    end
    chk("stream_accepts", 8'(n_acc), 3);
    chk("stream_drained", 8'(exp_q.size()), 0);
    check_rf("stream");

    // Randomized instructions
    for (int k = 0; k < 40; k++) begin
      issue(12'($urandom));
    end
    check_rf("rand");

    // Reset during EXEC of an ADD
    instr = enc(4'h0, 2'd0, 2'd1, 2'd2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("abort_in_exec", instr_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rv", res_valid, 0);
    chk("abort_ready_rst", instr_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) rf_m[r] = 4'h0;
    c_m = 1'b0;
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_carry", carry_flag, 0);
    check_rf("abort");
    @(posedge clk); #1;
    chk("abort_rv2", res_valid, 0);
    check_rf("abort2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
